// File: rtl/motor_cmd_sequencer.sv
// Two-port motion command arbiter driving the one-hot H-bridge direction bus,
// with dead time between differing movements, per-command run duration and estop.
module motor_cmd_sequencer #(
  parameter int TICK_DIV    = 125000,
  parameter int DEAD_CYCLES = 12500000
) (
  input  logic        clk_125mhz,
  input  logic        reset,
  input  logic        estop,
  input  logic        cmd0_valid,
  input  logic [4:0]  cmd0_dir,
  input  logic [15:0] cmd0_dur,
  output logic        cmd0_ready,
  input  logic        cmd1_valid,
  input  logic [4:0]  cmd1_dir,
  input  logic [15:0] cmd1_dur,
  output logic        cmd1_ready,
  output logic [4:0]  direction,
  output logic        busy,
  output logic        grant_id,
  output logic        done,
  output logic        cmd_err,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DEAD = 2'd2;

  localparam logic [4:0] DIR_FWD   = 5'b00001;
  localparam logic [4:0] DIR_IDLE  = 5'b00010;
  localparam logic [4:0] DIR_BWD   = 5'b00100;
  localparam logic [4:0] DIR_LEFT  = 5'b01000;
  localparam logic [4:0] DIR_RIGHT = 5'b10000;

  localparam int PW = $clog2(TICK_DIV + 1);
  localparam int DW = $clog2(DEAD_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEAD_LOAD  = DW'(DEAD_CYCLES);

  logic [1:0]    state;
  logic [PW-1:0] presc;
  logic [15:0]   ticks;
  logic [DW-1:0] dead_cnt;
  logic [4:0]    pend_dir;
  logic [15:0]   pend_dur;

  logic        base;
  logic        hs0;
  logic        hs1;
  logic        acc;
  logic        acc_legal;
  logic        acc_take;
  logic [4:0]  acc_dir;
  logic [15:0] acc_dur;
  logic        acc_id;

  // Handshake: a transfer occurs on a rising edge where valid && ready; the
  // requester holds dir/dur stable from valid rising until that edge. Port 0
  // has fixed priority, so at most one transfer happens per cycle.
  always_comb begin
    base       = !estop && (state != S_DEAD);
    cmd0_ready = base;
    cmd1_ready = base && !cmd0_valid;
    hs0        = cmd0_valid && cmd0_ready;
    hs1        = cmd1_valid && cmd1_ready;
    acc        = hs0 || hs1;
    acc_dir    = hs0 ? cmd0_dir : cmd1_dir;
    acc_dur    = hs0 ? cmd0_dur : cmd1_dur;
    acc_id     = !hs0;
    case (acc_dir)
      DIR_FWD, DIR_IDLE, DIR_BWD, DIR_LEFT, DIR_RIGHT: acc_legal = 1'b1;
      default:                                         acc_legal = 1'b0;
    endcase
    acc_take   = acc && acc_legal;
  end

  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk_125mhz) begin
    if (reset) begin
      state     <= S_IDLE;
      direction <= DIR_IDLE;
      presc     <= '0;
      ticks     <= '0;
      dead_cnt  <= '0;
      pend_dir  <= DIR_IDLE;
      pend_dur  <= '0;
      grant_id  <= 1'b0;
      done      <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      done    <= 1'b0;
      cmd_err <= 1'b0;
      if (estop) begin
        state     <= S_IDLE;
        direction <= DIR_IDLE;
        presc     <= '0;
        ticks     <= '0;
        dead_cnt  <= '0;
      end else begin
        if (acc && !acc_legal) cmd_err <= 1'b1;
        if (acc_take) begin
          grant_id <= acc_id;
          presc    <= '0;
          if (acc_dir == DIR_IDLE) begin
            state     <= S_IDLE;
            direction <= DIR_IDLE;
            ticks     <= '0;
          end else if (state == S_IDLE || acc_dir == direction) begin
            state     <= S_RUN;
            direction <= acc_dir;
            ticks     <= acc_dur;
          end else begin
            state     <= S_DEAD;
            direction <= DIR_IDLE;
            ticks     <= '0;
            pend_dir  <= acc_dir;
            pend_dur  <= acc_dur;
            dead_cnt  <= DEAD_LOAD;
          end
        end else begin
          case (state)
            S_RUN: begin
              // ticks == 0 means hold until replaced
              if (ticks != 16'd0) begin
                if (presc == PRESC_LAST) begin
                  presc <= '0;
                  if (ticks == 16'd1) begin
                    state     <= S_IDLE;
                    direction <= DIR_IDLE;
                    ticks     <= '0;
                    done      <= 1'b1;
                  end else begin
                    ticks <= ticks - 16'd1;
                  end
                end else begin
                  presc <= presc + PW'(1);
                end
              end
            end
            S_DEAD: begin
              if (dead_cnt == DW'(1)) begin
                state     <= S_RUN;
                direction <= pend_dir;
                presc     <= '0;
                ticks     <= pend_dur;
                dead_cnt  <= '0;
              end else begin
                dead_cnt <= dead_cnt - DW'(1);
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// Bench for motor_cmd_sequencer: directed scenarios then random traffic,
// all checked against a cycle-count reference model of the command rules.
module tb_motor_cmd_sequencer;

  localparam int TICK_DIV    = 4;
  localparam int DEAD_CYCLES = 3;

  localparam logic [4:0] FWD   = 5'b00001;
  localparam logic [4:0] IDLE  = 5'b00010;
  localparam logic [4:0] BWD   = 5'b00100;
  localparam logic [4:0] LEFT  = 5'b01000;
  localparam logic [4:0] RIGHT = 5'b10000;

  logic        clk_125mhz = 1'b0;
  logic        reset;
  logic        estop;
  logic        cmd0_valid, cmd1_valid;
  logic [4:0]  cmd0_dir, cmd1_dir;
  logic [15:0] cmd0_dur, cmd1_dur;
  logic        cmd0_ready, cmd1_ready;
  logic [4:0]  direction;
  logic        busy, grant_id, done, cmd_err;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // clock / reset
  always #5 clk_125mhz = ~clk_125mhz;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  motor_cmd_sequencer #(.TICK_DIV(TICK_DIV), .DEAD_CYCLES(DEAD_CYCLES)) dut (
    .clk_125mhz(clk_125mhz), .reset(reset), .estop(estop),
    .cmd0_valid(cmd0_valid), .cmd0_dir(cmd0_dir), .cmd0_dur(cmd0_dur), .cmd0_ready(cmd0_ready),
    .cmd1_valid(cmd1_valid), .cmd1_dir(cmd1_dir), .cmd1_dur(cmd1_dur), .cmd1_ready(cmd1_ready),
    .direction(direction), .busy(busy), .grant_id(grant_id), .done(done),
    .cmd_err(cmd_err), .dbg_state(dbg_state)
  );

  // reference model: mode 0 idle, 1 running, 2 dead time
  int         m_mode, m_run_left, m_dead_left;
  logic [4:0] m_dir, m_pdir;
  logic [15:0] m_pdur;
  logic       m_grant, m_done, m_err, m_hs0, m_hs1;
  logic [8:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_run_left = 0; m_dead_left = 0;
    m_dir = IDLE; m_pdir = IDLE; m_pdur = 0; m_grant = 0;
  endtask

  task automatic model_step();
    logic [4:0]  d;
    logic [15:0] u;
    logic        id, take;
    m_done = 0; m_err = 0; m_hs0 = 0; m_hs1 = 0;
    if (reset) begin
      model_reset();
    end else if (estop) begin
      m_mode = 0; m_run_left = 0; m_dead_left = 0; m_dir = IDLE;
    end else begin
      m_hs0 = cmd0_valid && m_mode != 2;
      m_hs1 = cmd1_valid && !cmd0_valid && m_mode != 2;
      d  = m_hs0 ? cmd0_dir : cmd1_dir;
      u  = m_hs0 ? cmd0_dur : cmd1_dur;
      id = m_hs1;
      take = (m_hs0 || m_hs1) && ($countones(d) == 1);
      if ((m_hs0 || m_hs1) && !take) m_err = 1;
      if (take) begin
        m_grant = id;
        if (d == IDLE) begin
          m_mode = 0; m_dir = IDLE; m_run_left = 0;
        end else if (m_mode == 0 || d == m_dir) begin
          m_mode = 1; m_dir = d; m_run_left = u * TICK_DIV;
        end else begin
          m_mode = 2; m_dir = IDLE; m_pdir = d; m_pdur = u; m_dead_left = DEAD_CYCLES;
        end
      end else if (m_mode == 1 && m_run_left > 0) begin
        m_run_left--;
        if (m_run_left == 0) begin
          m_mode = 0; m_dir = IDLE; m_done = 1;
        end
      end else if (m_mode == 2) begin
        m_dead_left--;
        if (m_dead_left == 0) begin
          m_mode = 1; m_dir = m_pdir; m_run_left = m_pdur * TICK_DIV;
        end
      end
    end
    exp_q.push_back({m_done, m_err, m_grant, (m_mode != 0), m_dir});
  endtask

  // one clock: readies checked before the edge, registered outputs after it
  task automatic step();
    logic       r0;
    logic [8:0] e;
    #1;
    r0 = !estop && m_mode != 2;
    check("cmd0_ready", cmd0_ready, r0);
    check("cmd1_ready", cmd1_ready, r0 && !cmd0_valid);
    @(posedge clk_125mhz);
    model_step();
    #1;
    e = exp_q.pop_front();
    check("direction", direction, e[4:0]);
    check("busy", busy, e[5]);
    check("grant_id", grant_id, e[6]);
    check("cmd_err", cmd_err, e[7]);
    check("done", done, e[8]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input int port, input logic [4:0] d, input logic [15:0] u);
    logic got;
    got = 0;
    if (port == 0) begin cmd0_valid = 1; cmd0_dir = d; cmd0_dur = u; end
    else           begin cmd1_valid = 1; cmd1_dir = d; cmd1_dur = u; end
    for (int i = 0; i < 12 && !got; i++) begin
      step();
      got = (port == 0) ? m_hs0 : m_hs1;
    end
    check("send_accept", got, 1'b1);
    if (port == 0) cmd0_valid = 0; else cmd1_valid = 0;
  endtask

  task automatic rand_cmd(output logic [4:0] d, output logic [15:0] u);
    logic [4:0] legal [5];
    legal[0] = FWD; legal[1] = IDLE; legal[2] = BWD; legal[3] = LEFT; legal[4] = RIGHT;
    d = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : legal[$urandom_range(0, 4)];
    u = 16'($urandom_range(0, 3));
  endtask

  initial begin
    reset = 1; estop = 0;
    cmd0_valid = 0; cmd0_dir = IDLE; cmd0_dur = 0;
    cmd1_valid = 0; cmd1_dir = IDLE; cmd1_dur = 0;
    model_reset();
    @(posedge clk_125mhz);
    #1;
    step();
    reset = 0;
    check("reset_dir", direction, IDLE);
    check("reset_busy", busy, 1'b0);
    idle(2);

    // timed run with expiry
    send(1, FWD, 2);
    check("fwd_start", direction, FWD);
    idle(7);
    check("fwd_held", direction, FWD);
    idle(1);
    check("fwd_expire_dir", direction, IDLE);
    check("fwd_expire_done", done, 1'b1);
    check("fwd_expire_busy", busy, 1'b0);

    // reversal through dead time
    send(1, FWD, 0);
    send(1, BWD, 0);
    check("dead_dir", direction, IDLE);
    check("dead_ready", cmd0_ready, 1'b0);
    idle(2);
    check("dead_still_idle", direction, IDLE);
    idle(1);
    check("bwd_after_dead", direction, BWD);
    idle(10);
    check("bwd_hold", direction, BWD);

    // priority: both ports from idle
    send(0, IDLE, 0);
    cmd0_valid = 1; cmd0_dir = LEFT; cmd0_dur = 0;
    cmd1_valid = 1; cmd1_dir = RIGHT; cmd1_dur = 0;
    #1;
    check("prio_ready1", cmd1_ready, 1'b0);
    step();
    check("prio_dir", direction, LEFT);
    check("prio_grant", grant_id, 1'b0);
    cmd0_valid = 0;
    step();
    check("port1_grant", grant_id, 1'b1);
    cmd1_valid = 0;
    idle(3);
    check("right_after_dead", direction, RIGHT);

    // same-direction retrigger
    send(1, RIGHT, 5);
    idle(11);
    send(1, RIGHT, 1);
    check("retrig_dir", direction, RIGHT);
    idle(3);
    check("retrig_held", direction, RIGHT);
    idle(1);
    check("retrig_expire", direction, IDLE);

    // illegal code and explicit IDLE
    send(1, RIGHT, 0);
    send(0, 5'b00011, 0);
    check("illegal_err", cmd_err, 1'b1);
    check("illegal_dir", direction, RIGHT);
    send(0, IDLE, 0);
    check("idle_cmd_dir", direction, IDLE);
    check("idle_cmd_done", done, 1'b0);

    // estop during dead time
    send(1, FWD, 0);
    send(1, LEFT, 0);
    idle(1);
    estop = 1;
    step();
    check("estop_dir", direction, IDLE);
    check("estop_busy", busy, 1'b0);
    check("estop_ready", cmd0_ready, 1'b0);
    estop = 0;
    step();
    send(1, FWD, 0);
    check("post_estop_dir", direction, FWD);
    idle(5);
    check("pending_lost", direction, FWD);

    // random traffic
    for (int c = 0; c < 2500; c++) begin
      logic [4:0]  d;
      logic [15:0] u;
      if (!cmd0_valid || m_hs0) begin
        cmd0_valid = ($urandom_range(0, 5) == 0);
        rand_cmd(d, u); cmd0_dir = d; cmd0_dur = u;
      end
      if (!cmd1_valid || m_hs1) begin
        cmd1_valid = ($urandom_range(0, 3) == 0);
        rand_cmd(d, u); cmd1_dir = d; cmd1_dur = u;
      end
      estop = ($urandom_range(0, 39) == 0);
      reset = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 0; estop = 0; cmd0_valid = 0; cmd1_valid = 0;
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
